// File: rtl/m_ext_iter_pkg.sv
// m_ext_iter_pkg: shared encodings and helpers for the iterative M-extension unit
package m_ext_iter_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct3_e;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
  // MUL treats rs1 as unsigned: the low half of the product is sign-agnostic
  function automatic logic rs1_signed(input funct3_e f);
    return f inside {F_MULH, F_MULHSU, F_DIV, F_REM};
  endfunction
  function automatic logic rs2_signed(input funct3_e f);
    return f inside {F_MULH, F_DIV, F_REM};
  endfunction
endpackage

// File: rtl/m_ext_iter_if.sv
// m_ext_iter_if: request/result handshake bundle between EX and the M unit
interface m_ext_iter_if #(parameter int XLEN = 32);
  logic            ip_flush;
  logic            ip_valid;
  logic            op_ready;
  logic [XLEN-1:0] ip_rs1;
  logic [XLEN-1:0] ip_rs2;
  logic [2:0]      ip_funct_3;
  logic            op_valid;
  logic            ip_result_ready;
  logic [XLEN-1:0] op_result;
  logic            op_overflow;
  logic            op_div_zero;
  modport master (
    output ip_flush, ip_valid, ip_rs1, ip_rs2, ip_funct_3, ip_result_ready,
    input  op_ready, op_valid, op_result, op_overflow, op_div_zero
  );
  modport slave (
    input  ip_flush, ip_valid, ip_rs1, ip_rs2, ip_funct_3, ip_result_ready,
    output op_ready, op_valid, op_result, op_overflow, op_div_zero
  );
endinterface

// File: rtl/m_ext_div_core.sv
// m_ext_div_core: restoring divider on unsigned magnitudes, one quotient bit per step
module m_ext_div_core #(
  parameter int XLEN = 32
) (
  input  logic            ip_clk,
  input  logic            ip_rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic            last
);
  localparam int CW = $clog2(XLEN);
  logic [CW-1:0] cnt;
  logic [XLEN:0] shifted, diff;
  assign shifted = {rem, quo[XLEN-1]};
  assign diff = shifted - {1'b0, divisor};
  assign last = cnt == CW'(XLEN - 1);
  // quo starts as the dividend and fills with quotient bits from the right as dividend bits leave on the left
  always_ff @(posedge ip_clk or negedge ip_rst_n)
    if (!ip_rst_n) begin
      quo <= '0;
      rem <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      cnt <= '0;
    end else if (step) begin
      rem <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      quo <= {quo[XLEN-2:0], ~diff[XLEN]};
      cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/m_ext_iter.sv
// m_ext_iter: multi-cycle RV32M/RV64M multiply/divide unit with valid/ready on both sides
module m_ext_iter
  import m_ext_iter_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int MUL_BITS = 4
) (
  input logic         ip_clk,
  input logic         ip_rst_n,
  m_ext_iter_if.slave bus
);
  localparam int MUL_CYC = XLEN / MUL_BITS;
  localparam int CW = $clog2(MUL_CYC + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_e st, st_nx;
  logic [2:0] f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q, mc_q, res_q, abs1, abs2, quo, rem, res_c;
  logic [2*XLEN-1:0] acc_q, prod;
  logic [XLEN+MUL_BITS-1:0] sum;
  logic [CW-1:0] mcnt_q;
  logic neg_q, rneg_q, dz_q, ovf_q, dz_o, ovf_o;
  logic neg1, neg2, is_div, dz_c, ovf_c, accept, div_last;
  assign accept = bus.ip_valid & bus.op_ready & ~bus.ip_flush;
  assign is_div = f3_q[2];
  assign neg1 = rs1_signed(funct3_e'(f3_q)) & rs1_q[XLEN-1];
  assign neg2 = rs2_signed(funct3_e'(f3_q)) & rs2_q[XLEN-1];
  assign abs1 = neg1 ? -rs1_q : rs1_q;
  assign abs2 = neg2 ? -rs2_q : rs2_q;
  assign dz_c = is_div & ~|rs2_q;
  assign ovf_c = is_div & ~f3_q[0] & (rs1_q == MIN_NEG) & (&rs2_q);
  assign sum = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]}
             + {{MUL_BITS{1'b0}}, mc_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]};
  assign prod = neg_q ? -acc_q : acc_q;
  assign res_c = dz_q ? (f3_q[1] ? rs1_q : '1)
               : ovf_q ? (f3_q[1] ? '0 : MIN_NEG)
               : !is_div ? (f3_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
               : f3_q[1] ? (rneg_q ? -rem : rem) : (neg_q ? -quo : quo);
  assign bus.op_ready = st == S_IDLE;
  assign bus.op_valid = st == S_DONE;
  assign bus.op_result = res_q;
  assign bus.op_overflow = ovf_o;
  assign bus.op_div_zero = dz_o;
  m_ext_div_core #(.XLEN(XLEN)) u_div (
    .ip_clk   (ip_clk),
    .ip_rst_n (ip_rst_n),
    .load     (st == S_PREP),
    .step     (st == S_DIV),
    .dividend (abs1),
    .divisor  (abs2),
    .quo      (quo),
    .rem      (rem),
    .last     (div_last)
  );
  // state register
  always_ff @(posedge ip_clk or negedge ip_rst_n)
    if (!ip_rst_n) st <= S_IDLE;
    else st <= st_nx;
  // sequence prep -> iterate -> fix -> hold result; special cases skip iteration; flush always returns to idle
  always_comb begin
    st_nx = st;
    case (st)
      S_IDLE:  st_nx = accept ? S_PREP : S_IDLE;
      S_PREP:  st_nx = (dz_c | ovf_c) ? S_FIX : is_div ? S_DIV : S_MUL;
      S_MUL:   st_nx = (mcnt_q == CW'(MUL_CYC - 1)) ? S_FIX : S_MUL;
      S_DIV:   st_nx = div_last ? S_FIX : S_DIV;
      S_FIX:   st_nx = S_DONE;
      S_DONE:  st_nx = bus.ip_result_ready ? S_IDLE : S_DONE;
      default: st_nx = S_IDLE;
    endcase
    if (bus.ip_flush) st_nx = S_IDLE;
  end
  // operand capture, shift-add multiply on {high product, remaining multiplier}, result/flag registers
  always_ff @(posedge ip_clk or negedge ip_rst_n)
    if (!ip_rst_n) begin
      rs1_q  <= '0;
      rs2_q  <= '0;
      f3_q   <= '0;
      mc_q   <= '0;
      acc_q  <= '0;
      mcnt_q <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
      dz_o   <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      if (accept) begin
        rs1_q <= bus.ip_rs1;
        rs2_q <= bus.ip_rs2;
        f3_q  <= bus.ip_funct_3;
      end
      if (st == S_PREP) begin
        mc_q   <= abs1;
        acc_q  <= {{XLEN{1'b0}}, abs2};
        mcnt_q <= '0;
        neg_q  <= neg1 ^ neg2;
        rneg_q <= neg1;
        dz_q   <= dz_c;
        ovf_q  <= ovf_c;
      end
      if (st == S_MUL) begin
        acc_q  <= {sum, acc_q[XLEN-1:MUL_BITS]};
        mcnt_q <= mcnt_q + CW'(1);
      end
      if (st == S_FIX && !bus.ip_flush) begin
        res_q <= res_c;
        dz_o  <= dz_q;
        ovf_o <= ovf_q;
      end
      if ((st == S_DONE && bus.ip_result_ready) || bus.ip_flush) begin
        dz_o  <= 1'b0;
        ovf_o <= 1'b0;
      end
    end
endmodule

// File: tb/tb_m_ext_iter.sv
// tb_m_ext_iter: table vectors, handshake corner cases and random ops against a behavioural model
module tb_m_ext_iter;
  typedef struct packed {
    logic [63:0] r;
    logic        ov;
    logic        dz;
    logic [31:0] lat;
  } exp_t;
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
    logic        dz;
    int          lat;
  } vec_t;
  logic ip_clk_tb = 1'b0;
  logic rst_n, rst1_n, done1;
  int n_vec = 0;
  int n_bad = 0;
  m_ext_iter_if #(.XLEN(32)) b0 ();
  m_ext_iter_if #(.XLEN(64)) b1 ();
  m_ext_iter #(.XLEN(32), .MUL_BITS(4)) dut0 (.ip_clk(ip_clk_tb), .ip_rst_n(rst_n), .bus(b0));
  m_ext_iter #(.XLEN(64), .MUL_BITS(1)) dut1 (.ip_clk(ip_clk_tb), .ip_rst_n(rst1_n), .bus(b1));
  always #5 ip_clk_tb = ~ip_clk_tb;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // RISC-V M semantics from plain signed/unsigned arithmetic on wide integers
  function automatic exp_t model(input int xl, input int mb, input logic [2:0] f,
                                 input logic [63:0] a, input logic [63:0] b);
    logic [127:0] m;
    logic signed [127:0] ua, ub, sa, sb, t, mn;
    exp_t e;
    m = (128'd1 << xl) - 128'd1;
    ua = {64'd0, a} & m;
    ub = {64'd0, b} & m;
    sa = ua[xl-1] ? ua - (m + 128'd1) : ua;
    sb = ub[xl-1] ? ub - (m + 128'd1) : ub;
    mn = -(128'sd1 << (xl - 1));
    e = '0;
    e.lat = 32'(xl / mb + 2);
    t = '0;
    if (f == 3'd0) t = sa * sb;
    else if (f == 3'd1) t = (sa * sb) >>> xl;
    else if (f == 3'd2) t = (sa * ub) >>> xl;
    else if (f == 3'd3) t = (ua * ub) >> xl;
    else if (ub == 0) begin
      e.dz = 1'b1;
      e.lat = 32'd2;
      t = f[1] ? ua : m;
    end else if (!f[0] && sa == mn && sb == -128'sd1) begin
      e.ov = 1'b1;
      e.lat = 32'd2;
      t = f[1] ? 128'sd0 : sa;
    end else begin
      e.lat = 32'(xl + 2);
      t = f[0] ? (f[1] ? ua % ub : ua / ub) : (f[1] ? sa % sb : sa / sb);
    end
    e.r = 64'(t & m);
    return e;
  endfunction

  function automatic logic [63:0] pick(input int xl);
    logic [63:0] m;
    int k;
    m = (xl == 64) ? '1 : (64'd1 << xl) - 64'd1;
    k = $urandom_range(9, 0);
    return k == 0 ? 64'd0 : k == 1 ? m : k == 2 ? 64'd1 << (xl - 1)
         : k == 3 ? 64'($urandom_range(20, 0)) : {$urandom, $urandom} & m;
  endfunction

  task automatic run0(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold,
                      output logic [31:0] r, output logic ov, output logic dz, output int lat);
    logic stable;
    @(negedge ip_clk_tb);
    b0.ip_funct_3 = f;
    b0.ip_rs1 = a;
    b0.ip_rs2 = b;
    b0.ip_valid = 1'b1;
    @(posedge ip_clk_tb); #1;
    b0.ip_valid = 1'b0;
    lat = 0;
    while (!b0.op_valid && lat < 200) begin
      @(posedge ip_clk_tb); #1;
      lat++;
    end
    r = b0.op_result;
    ov = b0.op_overflow;
    dz = b0.op_div_zero;
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge ip_clk_tb); #1;
      if (b0.op_result !== r || {b0.op_overflow, b0.op_div_zero} !== {ov, dz} ||
          b0.op_valid !== 1'b1 || b0.op_ready !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", {63'd0, stable}, 64'd1);
    @(negedge ip_clk_tb);
    b0.ip_result_ready = 1'b1;
    @(posedge ip_clk_tb); #1;
    b0.ip_result_ready = 1'b0;
    chk("handoff32", {60'd0, b0.op_valid, b0.op_ready, b0.op_overflow, b0.op_div_zero}, 64'b0100);
  endtask

  task automatic run1(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                      output logic [63:0] r, output logic ov, output logic dz, output int lat);
    @(negedge ip_clk_tb);
    b1.ip_funct_3 = f;
    b1.ip_rs1 = a;
    b1.ip_rs2 = b;
    b1.ip_valid = 1'b1;
    @(posedge ip_clk_tb); #1;
    b1.ip_valid = 1'b0;
    lat = 0;
    while (!b1.op_valid && lat < 300) begin
      @(posedge ip_clk_tb); #1;
      lat++;
    end
    r = b1.op_result;
    ov = b1.op_overflow;
    dz = b1.op_div_zero;
    @(negedge ip_clk_tb);
    b1.ip_result_ready = 1'b1;
    @(posedge ip_clk_tb); #1;
    b1.ip_result_ready = 1'b0;
    chk("handoff64", {60'd0, b1.op_valid, b1.op_ready, b1.op_overflow, b1.op_div_zero}, 64'b0100);
  endtask

  // XLEN=64, MUL_BITS=1 instance: random regression in parallel
  initial begin
    logic [63:0] a, b, r;
    logic [2:0] f;
    logic ov, dz;
    int lat;
    exp_t e;
    done1 = 1'b0;
    rst1_n = 1'b0;
    b1.ip_flush = 1'b0;
    b1.ip_valid = 1'b0;
    b1.ip_result_ready = 1'b0;
    b1.ip_rs1 = '0;
    b1.ip_rs2 = '0;
    b1.ip_funct_3 = '0;
    repeat (3) @(negedge ip_clk_tb);
    rst1_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      f = 3'($urandom_range(7, 0));
      a = pick(64);
      b = pick(64);
      e = model(64, 1, f, a, b);
      run1(f, a, b, r, ov, dz, lat);
      chk($sformatf("x64_res[%0d] f=%0d a=%h b=%h", i, f, a, b), r, e.r);
      chk($sformatf("x64_flags[%0d]", i), {62'd0, ov, dz}, {62'd0, e.ov, e.dz});
      chk($sformatf("x64_lat[%0d]", i), 64'(lat), 64'(e.lat));
    end
    done1 = 1'b1;
  end

  // XLEN=32, MUL_BITS=4 instance: directed table, handshake corners, random regression
  initial begin
    vec_t tbl[$];
    logic [31:0] r, a, b;
    logic [2:0] f;
    logic ov, dz, seen;
    int lat;
    exp_t e;
    tbl.push_back('{3'b000, 32'd89211, 32'd1418, 32'd126501198, 1'b0, 1'b0, 10});
    tbl.push_back('{3'b000, -32'sd34406, -32'sd5042, 32'd173475052, 1'b0, 1'b0, 10});
    tbl.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 10});
    tbl.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 10});
    tbl.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0, 10});
    tbl.push_back('{3'b000, 32'd0, 32'd5, 32'd0, 1'b0, 1'b0, 10});
    tbl.push_back('{3'b100, 32'd7818989, 32'd23, 32'd339956, 1'b0, 1'b0, 34});
    tbl.push_back('{3'b110, 32'd7818989, 32'd23, 32'd1, 1'b0, 1'b0, 34});
    tbl.push_back('{3'b100, -32'sd7, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0, 34});
    tbl.push_back('{3'b110, -32'sd7, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0, 34});
    tbl.push_back('{3'b100, 32'h003AE27C, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 2});
    tbl.push_back('{3'b111, 32'h003AE27C, 32'd0, 32'h003AE27C, 1'b0, 1'b1, 2});
    tbl.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 2});
    tbl.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 2});
    tbl.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 34});
    tbl.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 34});
    rst_n = 1'b0;
    b0.ip_flush = 1'b0;
    b0.ip_valid = 1'b0;
    b0.ip_result_ready = 1'b0;
    b0.ip_rs1 = '0;
    b0.ip_rs2 = '0;
    b0.ip_funct_3 = '0;
    repeat (2) @(negedge ip_clk_tb);
    chk("reset", {28'd0, b0.op_valid, b0.op_ready, b0.op_overflow, b0.op_div_zero, b0.op_result},
        {28'd0, 4'b0100, 32'd0});
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      run0(tbl[i].f, tbl[i].a, tbl[i].b, 0, r, ov, dz, lat);
      chk($sformatf("vec%0d_res", i), {32'd0, r}, {32'd0, tbl[i].r});
      chk($sformatf("vec%0d_flags", i), {62'd0, ov, dz}, {62'd0, tbl[i].ov, tbl[i].dz});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
    end
    run0(3'b101, 32'd100, 32'd7, 5, r, ov, dz, lat);
    chk("hold_res", {32'd0, r}, 64'd14);
    // flush in the middle of a divide: unit goes idle and never presents a result
    @(negedge ip_clk_tb);
    b0.ip_funct_3 = 3'b100;
    b0.ip_rs1 = 32'd1000;
    b0.ip_rs2 = 32'd3;
    b0.ip_valid = 1'b1;
    @(posedge ip_clk_tb); #1;
    b0.ip_valid = 1'b0;
    repeat (10) @(posedge ip_clk_tb);
    @(negedge ip_clk_tb);
    b0.ip_flush = 1'b1;
    @(posedge ip_clk_tb); #1;
    b0.ip_flush = 1'b0;
    chk("flush_idle", {62'd0, b0.op_valid, b0.op_ready}, 64'b01);
    seen = 1'b0;
    repeat (40) begin
      @(posedge ip_clk_tb); #1;
      seen |= b0.op_valid;
    end
    chk("flush_no_result", {63'd0, seen}, 64'd0);
    run0(3'b100, 32'd7818989, 32'd23, 0, r, ov, dz, lat);
    chk("after_flush_res", {32'd0, r}, 64'd339956);
    chk("after_flush_lat", 64'(lat), 64'd34);
    // flush together with a request: no accept
    @(negedge ip_clk_tb);
    b0.ip_flush = 1'b1;
    b0.ip_valid = 1'b1;
    @(posedge ip_clk_tb); #1;
    b0.ip_flush = 1'b0;
    b0.ip_valid = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(posedge ip_clk_tb); #1;
      seen |= b0.op_valid | ~b0.op_ready;
    end
    chk("flush_beats_valid", {63'd0, seen}, 64'd0);
    // asynchronous reset in the middle of a multiply
    run0(3'b000, 32'd12345, 32'd678, 0, r, ov, dz, lat);
    chk("mul_pre_rst", {32'd0, r}, 64'd8369910);
    @(negedge ip_clk_tb);
    b0.ip_funct_3 = 3'b000;
    b0.ip_rs1 = 32'd999;
    b0.ip_rs2 = 32'd777;
    b0.ip_valid = 1'b1;
    @(posedge ip_clk_tb); #1;
    b0.ip_valid = 1'b0;
    repeat (3) @(posedge ip_clk_tb);
    @(negedge ip_clk_tb);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {28'd0, b0.op_valid, b0.op_ready, b0.op_overflow, b0.op_div_zero, b0.op_result},
        {28'd0, 4'b0100, 32'd0});
    @(negedge ip_clk_tb);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge ip_clk_tb); #1;
      seen |= b0.op_valid;
    end
    chk("rst_no_result", {63'd0, seen}, 64'd0);
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(7, 0));
      a = 32'(pick(32));
      b = 32'(pick(32));
      e = model(32, 4, f, {32'd0, a}, {32'd0, b});
      run0(f, a, b, 0, r, ov, dz, lat);
      chk($sformatf("x32_res[%0d] f=%0d a=%h b=%h", i, f, a, b), {32'd0, r}, e.r);
      chk($sformatf("x32_flags[%0d]", i), {62'd0, ov, dz}, {62'd0, e.ov, e.dz});
      chk($sformatf("x32_lat[%0d]", i), 64'(lat), 64'(e.lat));
    end
    for (int k = 0; k < 20000 && !done1; k++) @(posedge ip_clk_tb);
    chk("x64_done", {63'd0, done1}, 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
